// File: rtl/display_pkg.sv
// Shared constants for the two-digit hex display path: segment lookup table,
// blank pattern, segment bit positions and a polarity helper.
package display_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high patterns for nibbles 0..F, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/hex_display_feeder_if.sv
// Bus between the display feeder and whatever supplies its values and
// consumes its segment patterns.
interface hex_display_feeder_if;
    // load is a one-cycle strobe with no back-pressure: it is always accepted,
    // and pending stays high until the captured value reaches the display.
    logic [7:0] value_in;
    logic       load;
    logic       pending;
    logic       divided_clk;
    logic [6:0] disp0;
    logic [6:0] disp1;

    modport master (
        output value_in, load,
        input  pending, divided_clk, disp0, disp1
    );

    modport slave (
        input  value_in, load,
        output pending, divided_clk, disp0, disp1
    );
endinterface

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-high seven-segment pattern lookup.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_LUT[nibble_i];
endmodule

// File: rtl/hex_display_feeder.sv
// Holds an 8-bit value, swaps in new values only at a refresh frame boundary,
// and drives registered segment patterns plus the digit-select toggle.
module hex_display_feeder
    import display_pkg::*;
#(
    parameter int DIV_WIDTH      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hex_display_feeder_if.slave  bus
);
    localparam logic [6:0] DISP0_RST = seg_polarity(SEG_LUT[0], SEG_ACTIVE_LOW);
    localparam logic [6:0] DISP1_RST =
        seg_polarity(BLANK_LEADING ? SEG_BLANK : SEG_LUT[0], SEG_ACTIVE_LOW);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 div_q, div_d;
    logic [7:0]           shown_q, shown_d;
    logic [7:0]           pend_val_q, pend_val_d;
    logic                 pending_q, pending_d;
    logic [6:0]           disp0_q, disp0_d;
    logic [6:0]           disp1_q, disp1_d;

    logic       wrap;
    logic       boundary;
    logic [6:0] seg_lo;
    logic [6:0] seg_hi;

    hex_to_seg u_seg_lo (.nibble_i(shown_q[3:0]), .seg_o(seg_lo));
    hex_to_seg u_seg_hi (.nibble_i(shown_q[7:4]), .seg_o(seg_hi));

    assign wrap     = (cnt_q == {DIV_WIDTH{1'b1}});
    // End of the disp1 phase: both digits have been refreshed with the old pair.
    assign boundary = wrap && div_q;

    always_comb begin
        cnt_d      = cnt_q + DIV_WIDTH'(1);
        div_d      = wrap ? ~div_q : div_q;
        shown_d    = shown_q;
        pend_val_d = pend_val_q;
        pending_d  = pending_q;

        if (boundary && pending_q) begin
            shown_d   = pend_val_q;
            pending_d = 1'b0;
        end
        // A load on the boundary re-arms pending for the following frame.
        if (bus.load) begin
            pend_val_d = bus.value_in;
            pending_d  = 1'b1;
        end

        disp0_d = seg_polarity(seg_lo, SEG_ACTIVE_LOW);
        disp1_d = seg_polarity((BLANK_LEADING && shown_q[7:4] == 4'h0) ? SEG_BLANK : seg_hi,
                               SEG_ACTIVE_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= 1'b0;
            shown_q    <= 8'h00;
            pend_val_q <= 8'h00;
            pending_q  <= 1'b0;
            disp0_q    <= DISP0_RST;
            disp1_q    <= DISP1_RST;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            shown_q    <= shown_d;
            pend_val_q <= pend_val_d;
            pending_q  <= pending_d;
            disp0_q    <= disp0_d;
            disp1_q    <= disp1_d;
        end
    end

    assign bus.pending     = pending_q;
    assign bus.divided_clk = div_q;
    assign bus.disp0       = disp0_q;
    assign bus.disp1       = disp1_q;

endmodule

// File: tb/tb_hex_display_feeder.sv
// Directed bench for hex_display_feeder with a 4-cycle refresh half-period;
// a second instance checks the unblanked leading digit.
module tb_hex_display_feeder;

    logic clk;
    logic rst_n;

    hex_display_feeder_if ifc ();
    hex_display_feeder_if ifc_b ();

    assign ifc_b.value_in = ifc.value_in;
    assign ifc_b.load     = ifc.load;

    hex_display_feeder #(.DIV_WIDTH(2), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    hex_display_feeder #(.DIV_WIDTH(2), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc_b.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Each tick ends on a falling edge, where outputs are sampled and inputs driven.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_load(input logic [7:0] v);
        ifc.value_in = v;
        ifc.load     = 1'b1;
        tick(1);
        ifc.load     = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        ifc.value_in = 8'h00;
        ifc.load     = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_disp0",   {1'b0, ifc.disp0}, 8'h40);
        check_eq("rst_disp1",   {1'b0, ifc.disp1}, 8'h7F);
        check_eq("rst_div",     {7'd0, ifc.divided_clk}, 8'h00);
        check_eq("rst_pending", {7'd0, ifc.pending}, 8'h00);
        check_eq("rst_b_disp0", {1'b0, ifc_b.disp0}, 8'h40);
        check_eq("rst_b_disp1", {1'b0, ifc_b.disp1}, 8'h40);

        // k = number of rising edges since release; boundary edges are k = 8, 16, ...
        rst_n = 1'b1;
        tick(3);
        check_eq("div_k3", {7'd0, ifc.divided_clk}, 8'h00);
        tick(1);
        check_eq("div_k4", {7'd0, ifc.divided_clk}, 8'h01);
        tick(3);
        check_eq("div_k7", {7'd0, ifc.divided_clk}, 8'h01);
        tick(1);
        check_eq("div_k8", {7'd0, ifc.divided_clk}, 8'h00);

        // basic load, captured at k=9, applied at k=16, visible at k=17
        pulse_load(8'h3A);
        check_eq("basic_pend_k9", {7'd0, ifc.pending}, 8'h01);
        tick(6);
        check_eq("basic_pend_k15", {7'd0, ifc.pending}, 8'h01);
        check_eq("basic_disp0_k15", {1'b0, ifc.disp0}, 8'h40);
        check_eq("basic_disp1_k15", {1'b0, ifc.disp1}, 8'h7F);
        tick(1);
        check_eq("basic_pend_k16", {7'd0, ifc.pending}, 8'h00);
        check_eq("basic_disp0_k16", {1'b0, ifc.disp0}, 8'h40);
        tick(1);
        check_eq("basic_disp0_k17", {1'b0, ifc.disp0}, 8'h08);
        check_eq("basic_disp1_k17", {1'b0, ifc.disp1}, 8'h30);

        // overwrite: 12 at k=18, 45 at k=20; display must hold 3A through k=24
        pulse_load(8'h12);
        tick(1);
        pulse_load(8'h45);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h08);
            check_eq("ovw_hold_disp0", {1'b0, ifc.disp0}, exp_q.pop_front());
            tick(1);
        end
        check_eq("ovw_disp0_k25", {1'b0, ifc.disp0}, 8'h12);
        check_eq("ovw_disp1_k25", {1'b0, ifc.disp1}, 8'h19);
        check_eq("ovw_pend_k25",  {7'd0, ifc.pending}, 8'h00);

        // 21 pending, then 99 loaded on the k=32 boundary edge
        pulse_load(8'h21);
        tick(5);
        pulse_load(8'h99);
        check_eq("coin_pend_k32", {7'd0, ifc.pending}, 8'h01);
        tick(1);
        check_eq("coin_disp0_k33", {1'b0, ifc.disp0}, 8'h79);
        check_eq("coin_disp1_k33", {1'b0, ifc.disp1}, 8'h24);
        check_eq("coin_pend_k33",  {7'd0, ifc.pending}, 8'h01);
        tick(7);
        check_eq("coin_pend_k40", {7'd0, ifc.pending}, 8'h00);
        tick(1);
        check_eq("coin_disp0_k41", {1'b0, ifc.disp0}, 8'h10);
        check_eq("coin_disp1_k41", {1'b0, ifc.disp1}, 8'h10);

        // leading-digit blanking, applied at k=48
        pulse_load(8'h07);
        tick(7);
        check_eq("blank_disp0",   {1'b0, ifc.disp0}, 8'h78);
        check_eq("blank_disp1",   {1'b0, ifc.disp1}, 8'h7F);
        check_eq("blank_b_disp0", {1'b0, ifc_b.disp0}, 8'h78);
        check_eq("blank_b_disp1", {1'b0, ifc_b.disp1}, 8'h40);

        // asynchronous reset between edges with FF pending
        pulse_load(8'hFF);
        check_eq("async_pend_set", {7'd0, ifc.pending}, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_disp0",   {1'b0, ifc.disp0}, 8'h40);
        check_eq("async_disp1",   {1'b0, ifc.disp1}, 8'h7F);
        check_eq("async_pend",    {7'd0, ifc.pending}, 8'h00);
        check_eq("async_div",     {7'd0, ifc.divided_clk}, 8'h00);
        check_eq("async_b_disp1", {1'b0, ifc_b.disp1}, 8'h40);
        ifc.value_in = 8'hFF;
        ifc.load     = 1'b1;
        tick(2);
        ifc.load = 1'b0;
        rst_n    = 1'b1;
        tick(17);
        check_eq("post_rst_disp0", {1'b0, ifc.disp0}, 8'h40);
        check_eq("post_rst_disp1", {1'b0, ifc.disp1}, 8'h7F);
        check_eq("post_rst_pend",  {7'd0, ifc.pending}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
